// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package riscv_mem_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker between fetch and data requests.
module rr_arbiter2
  import riscv_mem_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_fetch_i,
  input  logic req_data_i,
  input  logic update_i,
  output logic valid_o,
  output logic pick_data_o
);

  port_id_t last_q;
  port_id_t pick;

  // On a tie pick the port that lost last time; a lone request always wins.
  always_comb begin
    pick = PORT_I;
    if (req_fetch_i && req_data_i) begin
      pick = (last_q == PORT_I) ? PORT_D : PORT_I;
    end else if (req_data_i) begin
      pick = PORT_D;
    end
  end

  assign valid_o     = req_fetch_i | req_data_i;
  assign pick_data_o = (pick == PORT_D);

  // Last-grant register; starts at I so the first tie goes to D.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT_I;
    end else if (update_i) begin
      last_q <= pick;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports,
// one transaction in flight, with round-robin arbitration and wait timeout.
module mem_arbiter #(
  parameter int unsigned XLEN           = riscv_mem_pkg::XLEN,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_i_req,
  input  logic [XLEN-1:0] i_i_addr,
  input  logic            i_d_req,
  input  logic            i_d_we,
  input  logic [XLEN-1:0] i_d_addr,
  input  logic [XLEN-1:0] i_d_wdata,
  output logic            o_i_gnt,
  output logic            o_d_gnt,
  output logic            o_i_rvalid,
  output logic            o_d_rvalid,
  output logic [XLEN-1:0] o_i_rdata,
  output logic [XLEN-1:0] o_d_rdata,
  output logic            o_i_err,
  output logic            o_d_err,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_rdata
);

  import riscv_mem_pkg::*;

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t      state_q;
  port_id_t        owner_q;
  logic            armed_q;     // blocks arbitration on the first edge after reset
  logic [CntW-1:0] wait_cnt_q;

  logic     arb_valid;
  logic     arb_pick_data;
  port_id_t arb_pick;
  logic     arb_take;
  logic     timed_out;
  logic     done;

  assign arb_pick  = arb_pick_data ? PORT_D : PORT_I;
  assign arb_take  = (state_q == IDLE) && armed_q && arb_valid;
  assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == CntLast);
  assign done      = i_mem_ready || timed_out;

  rr_arbiter2 u_rr (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .req_fetch_i (i_i_req),
    .req_data_i  (i_d_req),
    .update_i    (arb_take),
    .valid_o     (arb_valid),
    .pick_data_o (arb_pick_data)
  );

  // Transaction FSM with registered memory and response outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      owner_q     <= PORT_I;
      armed_q     <= 1'b0;
      wait_cnt_q  <= '0;
      o_i_gnt     <= 1'b0;
      o_d_gnt     <= 1'b0;
      o_i_rvalid  <= 1'b0;
      o_d_rvalid  <= 1'b0;
      o_i_rdata   <= '0;
      o_d_rdata   <= '0;
      o_i_err     <= 1'b0;
      o_d_err     <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      armed_q    <= 1'b1;
      o_i_gnt    <= 1'b0;
      o_d_gnt    <= 1'b0;
      o_i_rvalid <= 1'b0;
      o_d_rvalid <= 1'b0;
      o_i_rdata  <= '0;
      o_d_rdata  <= '0;
      o_i_err    <= 1'b0;
      o_d_err    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_take) begin
            state_q    <= ACCESS;
            owner_q    <= arb_pick;
            wait_cnt_q <= '0;
            o_mem_req  <= 1'b1;
            if (arb_pick == PORT_D) begin
              o_d_gnt     <= 1'b1;
              o_mem_we    <= i_d_we;
              o_mem_addr  <= i_d_addr;
              o_mem_wdata <= i_d_wdata;
            end else begin
              o_i_gnt     <= 1'b1;
              o_mem_we    <= 1'b0;
              o_mem_addr  <= i_i_addr;
              o_mem_wdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (done) begin
            // Ready has priority over a coincident timeout.
            state_q     <= IDLE;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            if (owner_q == PORT_D) begin
              o_d_rvalid <= 1'b1;
              o_d_err    <= !i_mem_ready;
              o_d_rdata  <= (i_mem_ready && !o_mem_we) ? i_mem_rdata : '0;
            end else begin
              o_i_rvalid <= 1'b1;
              o_i_err    <= !i_mem_ready;
              o_i_rdata  <= i_mem_ready ? i_mem_rdata : '0;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
